// File: rtl/morse_seq_mem_if.sv
// ---------------------------------------------------------------------------
// morse_seq_mem_if
// CPU data-bus bundle for the Morse/seven-segment peripheral.
//   data  : write data (master -> slave)
//   addr  : word address (master -> slave)
//   we    : write enable, qualified by en
//   en    : block select; an access happens on any clk edge with en=1
//   rdata : registered read data (slave -> master)
// ---------------------------------------------------------------------------
interface morse_seq_mem_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  en;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output data, addr, we, en, input rdata);
    modport slave  (input data, addr, we, en, output rdata);
endinterface

// File: rtl/morse_seq_mem.sv
// ---------------------------------------------------------------------------
// morse_seq_mem
// Memory-mapped output peripheral: NUM_DIGITS hex seven-segment digits plus a
// Morse LED that autonomously plays a programmable on/off bit pattern, one bit
// per programmable unit, with optional looping and a fixed inter-repeat gap.
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   bus       : slave side of the CPU bus (data, addr, we, en, rdata)
//   morse_led : LED drive, 1 = on
//   sevseg    : digit k at [7k+6:7k], active-low, gfedcba
//   busy      : sequencer is in PLAY or GAP
// Address map: addr[10]=0 digits (index addr[3:0]); addr[10]=1 Morse regs at
// addr[4:0]: 0 CTRL {busy,loop,run}, 1 LEN, 2 UNIT_LO, 3 UNIT_HI, 4+k PATTERN k.
// ---------------------------------------------------------------------------
module morse_seq_mem #(
    parameter int          DATA_WIDTH   = 16,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          NUM_DIGITS   = 2,
    parameter int          PATTERN_BITS = 64,
    parameter int          UNIT_W       = 24,
    parameter int unsigned UNIT_DEFAULT = 12499999,
    parameter int          GAP_UNITS    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    morse_seq_mem_if.slave          bus,
    output logic                    morse_led,
    output logic [7*NUM_DIGITS-1:0] sevseg,
    output logic                    busy
);
    localparam int NWORDS = PATTERN_BITS / 16;
    localparam int IDX_W  = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;
    localparam int LEN_W  = $clog2(PATTERN_BITS + 1);
    localparam int GAP_W  = $clog2(GAP_UNITS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;

    state_t                  state_q;
    logic                    run_q;
    logic                    loop_q;
    logic                    led_q;
    logic [LEN_W-1:0]        len_q;
    logic [UNIT_W-1:0]       unit_q;
    logic [UNIT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [GAP_W-1:0]        gap_q;
    logic [15:0]             pattern_q [NWORDS];
    logic [6:0]              digit_q [NUM_DIGITS];
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [PATTERN_BITS-1:0] pattern_flat;
    logic [4:0]              off;
    logic                    boundary;
    logic                    last_bit;
    logic [IDX_W-1:0]        idx_inc;
    logic [LEN_W:0]          idx_plus1;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_pat
            assign pattern_flat[16*gi +: 16] = pattern_q[gi];
        end
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            assign sevseg[7*gi +: 7] = digit_q[gi];
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign off       = bus.addr[4:0];
    // cnt free-runs through the full UNIT_W range, so a UNIT shrunk below cnt
    // is still hit after the wrap instead of never.
    assign boundary  = (cnt_q == unit_q);
    assign idx_inc   = idx_q + IDX_W'(1);
    assign idx_plus1 = (LEN_W+1)'(idx_q) + (LEN_W+1)'(1);
    // ">=" rather than "==" so a LEN written at or below idx ends the sequence.
    assign last_bit  = (idx_plus1 >= {1'b0, len_q});

    assign busy        = (state_q != ST_IDLE);
    assign morse_led   = led_q;
    assign bus.rdata   = rdata_q;
    assign unused_bits = ^{bus.addr, bus.data};

    always_comb begin
        rdata_d = '0;
        if (bus.addr[10]) begin
            if (off == 5'd0) begin
                rdata_d[2:0] = {busy, loop_q, run_q};
            end else if (off == 5'd1) begin
                rdata_d[LEN_W-1:0] = len_q;
            end
            for (int k = 0; k < NWORDS; k++) begin
                if (off == 5'(4 + k)) begin
                    rdata_d[15:0] = pattern_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            loop_q  <= 1'b0;
            led_q   <= 1'b0;
            len_q   <= '0;
            unit_q  <= UNIT_W'(UNIT_DEFAULT);
            cnt_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            rdata_q <= '0;
            for (int k = 0; k < NWORDS; k++)     pattern_q[k] <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) digit_q[k]   <= 7'h7F;
        end else begin
            if (bus.en && !bus.we) begin
                rdata_q <= rdata_d;
            end

            // Sequencer; a CTRL write below overrides whatever is decided here.
            case (state_q)
                ST_PLAY: begin
                    if (boundary) begin
                        cnt_q <= '0;
                        if (last_bit) begin
                            idx_q <= '0;
                            gap_q <= '0;
                            led_q <= 1'b0;
                            if (loop_q) begin
                                state_q <= ST_GAP;
                            end else begin
                                state_q <= ST_IDLE;
                                run_q   <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_inc;
                            led_q <= pattern_flat[idx_inc];
                        end
                    end else begin
                        cnt_q <= cnt_q + UNIT_W'(1);
                        led_q <= pattern_flat[idx_q];
                    end
                end
                ST_GAP: begin
                    if (boundary) begin
                        cnt_q <= '0;
                        if (gap_q == GAP_W'(GAP_UNITS - 1)) begin
                            gap_q <= '0;
                            idx_q <= '0;
                            if (loop_q) begin
                                state_q <= ST_PLAY;
                                led_q   <= pattern_flat[0];
                            end else begin
                                state_q <= ST_IDLE;
                                run_q   <= 1'b0;
                                led_q   <= 1'b0;
                            end
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + UNIT_W'(1);
                    end
                end
                default: begin
                    led_q <= 1'b0;
                end
            endcase

            if (bus.en && bus.we) begin
                if (!bus.addr[10]) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (bus.addr[3:0] == 4'(k)) digit_q[k] <= hex7(bus.data[3:0]);
                    end
                end else begin
                    case (off)
                        5'd0: begin
                            loop_q <= bus.data[1];
                            idx_q  <= '0;
                            cnt_q  <= '0;
                            gap_q  <= '0;
                            if (bus.data[0] && (len_q != '0)) begin
                                run_q   <= 1'b1;
                                state_q <= ST_PLAY;
                                led_q   <= pattern_flat[0];
                            end else begin
                                run_q   <= 1'b0;
                                state_q <= ST_IDLE;
                                led_q   <= 1'b0;
                            end
                        end
                        5'd1: begin
                            if (bus.data > DATA_WIDTH'(PATTERN_BITS)) len_q <= LEN_W'(PATTERN_BITS);
                            else                                      len_q <= LEN_W'(bus.data);
                        end
                        5'd2: unit_q[15:0]        <= bus.data[15:0];
                        5'd3: unit_q[UNIT_W-1:16] <= bus.data[UNIT_W-17:0];
                        default: begin
                            for (int k = 0; k < NWORDS; k++) begin
                                if (off == 5'(4 + k)) pattern_q[k] <= bus.data[15:0];
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule
